inv_rotate_module: RTL and testbench
====================================

Name: inv_rotate_module

Overview:
- Inverse of the Keccak rho lane rotation: takes a rotated 64-bit lane plus its lane index and restores the original lane.
- Computes newLane[z] = lane[(z + T[laneid]) mod 64], processing BITS_PER_CYCLE bits per clock.
- Sits on the inverse-permutation / verification path beside the forward rotate stage.
- Uses valid/ready handshakes on input and output so it can be chained with the lane buffer and the pi/chi stages.

Parameters:
- BITS_PER_CYCLE, 1, bits written per ROTATE cycle; legal values 1, 2, 4, 8, 16, 32, 64. Any other value is a configuration error.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  lane/laneid valid
- in_ready  output  1  block can accept a lane
- lane  input  64  rotated lane to be restored
- laneid  input  5  lane index 0..24
- out_valid  output  1  newLane holds the result
- out_ready  input  1  consumer accepts the result
- newLane  output  64  restored lane
- busy  output  1  high in ROTATE and DONE
- lane_err  output  1  one-cycle pulse when an accepted laneid is greater than 24

Behaviour:
- Offset table T[0..24] = 21, 8, 41, 45, 15, 56, 14, 18, 2, 61, 28, 27, 0, 1, 62, 55, 20, 36, 44, 6, 25, 39, 3, 10, 43.
- laneid 0 is always the identity (offset 0), matching the forward stage.
- laneid 25..31: treated as identity, and lane_err pulses for 1 cycle in the cycle after acceptance.
- Index arithmetic is 7-bit: zSrc = z + T; if zSrc >= 64, subtract 64. No index outside 0..63 is ever read.
- On acceptance the block registers lane into srcReg and the effective offset into offReg. Later changes on lane/laneid have no effect on the job in flight.
- Reset (rst=0, asynchronous):
  - state=IDLE, z counter=0, srcReg=0, newLane=0, offReg=0
  - in_ready=1, out_valid=0, busy=0, lane_err=0
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1 (acceptance) → ROTATE, with z=0 and newLane cleared to 0.
  - ROTATE: in_ready=0. Each cycle, for k = 0..BITS_PER_CYCLE-1: newLane[z+k] <= srcReg[(z+k+offReg) mod 64]; then z += BITS_PER_CYCLE. When the write covers index 63, go to DONE next cycle, with z reset to 0.
  - ROTATE length is exactly 64/BITS_PER_CYCLE cycles.
  - DONE: out_valid=1 and newLane held stable until out_ready=1. That cycle counts as the output handshake → IDLE.
  - out_valid drops the cycle after the handshake. in_ready returns to 1 in that same cycle.
- No overlap between jobs: a new lane is accepted only in IDLE.
- Latency with BITS_PER_CYCLE=1: acceptance at edge N, out_valid high from edge N+65.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored; no data is lost, because in_ready=0 there.
- Reset asserted mid-ROTATE or mid-DONE aborts the job immediately and returns to the reset values. There is no partial output.
- newLane bits not yet written read 0 during ROTATE. Only the DONE value is architecturally valid.

Optional Feature:
- Macro INV_ROT_BYPASS_EN.
- Defined: when the effective offset is 0 (laneid 0, laneid 12, or laneid > 24), on acceptance newLane <= lane directly and the FSM goes IDLE→DONE, with out_valid high 1 cycle after acceptance. ROTATE is skipped.
- Undefined: every lane takes the full 64/BITS_PER_CYCLE ROTATE cycles regardless of offset.
- Results are bit-identical in both builds. Only latency differs.

Test Plan:
- BPC=1, lane=64'h1, laneid=1 (T=8) → newLane=64'h0100_0000_0000_0000; out_valid high exactly 65 cycles after acceptance.
- lane=64'h1, laneid=9 (T=61) → newLane=64'h8. lane=64'h8000_0000_0000_0000, laneid=14 (T=62) → newLane=64'h2. These two cases check the mod-64 wrap.
- Round trip, all 25 laneids with random lanes: forward rotate, then this block → output equals the original lane. laneid=0 with lane=64'hDEAD_BEEF_0123_4567 → identical output.
- Backpressure and error path:
  - Hold out_ready=0 for 10 cycles in DONE → newLane stable, out_valid=1, in_ready=0, and a new in_valid is ignored.
  - laneid=27 → identity result, with lane_err pulsed for 1 cycle.
- Reset and bypass:
  - Drive rst=0 at z=30 → all outputs at reset values asynchronously. A fresh job after release completes correctly.
  - With INV_ROT_BYPASS_EN, laneid=12 → out_valid high 1 cycle after acceptance.

Source files
------------

// File: rtl/inv_rotate_module.sv
// inv_rotate_module: undoes the Keccak rho lane rotation.
//   newLane[z] = lane[(z + T[laneid]) mod 64], BITS_PER_CYCLE bits per clock.
// Valid/ready handshakes on the input and output sides. A new job is accepted only in IDLE.
// Optional macro INV_ROT_BYPASS_EN: a lane whose effective offset is 0 is copied
// straight into newLane and goes IDLE -> DONE, skipping ROTATE.
// The result is bit-identical in both builds. Only the latency changes.
module inv_rotate_module #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] lane,
  input  logic [4:0]  laneid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] newLane,
  output logic        busy,
  output logic        lane_err
);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32 ||
        BITS_PER_CYCLE == 64)) begin : g_cfg_err
    $error("inv_rotate_module: BITS_PER_CYCLE must be a power of two from 1 to 64");
  end

`ifdef INV_ROT_BYPASS_EN
  localparam bit c_bypass_en = 1'b1;
`else
  localparam bit c_bypass_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Rho offset per lane index. Indices 25..31 are not real lanes and map to identity.
  function automatic logic [5:0] rho_offset(input logic [4:0] id);
    logic [5:0] off;
    case (id)
      5'd0:    off = 6'd21;
      5'd1:    off = 6'd8;
      5'd2:    off = 6'd41;
      5'd3:    off = 6'd45;
      5'd4:    off = 6'd15;
      5'd5:    off = 6'd56;
      5'd6:    off = 6'd14;
      5'd7:    off = 6'd18;
      5'd8:    off = 6'd2;
      5'd9:    off = 6'd61;
      5'd10:   off = 6'd28;
      5'd11:   off = 6'd27;
      5'd12:   off = 6'd0;
      5'd13:   off = 6'd1;
      5'd14:   off = 6'd62;
      5'd15:   off = 6'd55;
      5'd16:   off = 6'd20;
      5'd17:   off = 6'd36;
      5'd18:   off = 6'd44;
      5'd19:   off = 6'd6;
      5'd20:   off = 6'd25;
      5'd21:   off = 6'd39;
      5'd22:   off = 6'd3;
      5'd23:   off = 6'd10;
      5'd24:   off = 6'd43;
      default: off = 6'd0;
    endcase
    // Lane 0 is forced to identity so that it matches the forward stage.
    if (id == 5'd0) begin
      off = 6'd0;
    end else begin
      off = off;
    end
    return off;
  endfunction

  state_t      r_state;
  logic [5:0]  r_z;
  logic [63:0] r_src;
  logic [5:0]  r_off;
  logic [63:0] r_new_lane;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_lane_err;

  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_bypass;
  logic        w_handshake;
  logic [5:0]  w_off;
  logic [6:0]  w_z_sum;
  logic        w_last;
  logic [63:0] w_rot;

  assign w_off       = rho_offset(laneid);
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_bypass    = c_bypass_en && (w_off == 6'd0);
  assign w_handshake = (r_state == S_DONE) && r_out_valid && out_ready;
  // The 7-bit sum reaches 64 exactly when this cycle writes bit 63.
  assign w_z_sum     = {1'b0, r_z} + 7'(BITS_PER_CYCLE);
  assign w_last      = w_z_sum[6];

  // Next-state logic for the IDLE / ROTATE / DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_bypass ? S_DONE : S_ROTATE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ROTATE: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ROTATE;
        end
      end
      S_DONE: begin
        if (w_handshake) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // This cycle's slice of the rotation: write newLane[z+k] from srcReg[(z+k+off) mod 64].
  always_comb begin
    logic [6:0] v_idx;
    logic [6:0] v_src;
    w_rot = r_new_lane;
    v_idx = 7'd0;
    v_src = 7'd0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      v_idx = {1'b0, r_z} + 7'(k);
      v_src = v_idx + {1'b0, r_off};
      if (v_src >= 7'd64) begin
        v_src = v_src - 7'd64;
      end else begin
        v_src = v_src;
      end
      w_rot[v_idx[5:0]] = r_src[v_src[5:0]];
    end
  end

  // Control registers: state, handshake flags, busy and the error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_lane_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_lane_err  <= w_accept && (laneid > 5'd24);
      r_out_valid <= (r_state == S_DONE) && !w_handshake;
    end
  end

  // Datapath registers: capture the job on acceptance, then build newLane while in ROTATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z        <= 6'd0;
      r_src      <= 64'd0;
      r_off      <= 6'd0;
      r_new_lane <= 64'd0;
    end else if (w_accept) begin
      r_z        <= 6'd0;
      r_src      <= lane;
      r_off      <= w_off;
      r_new_lane <= w_bypass ? lane : 64'd0;
    end else if (r_state == S_ROTATE) begin
      r_z        <= w_z_sum[5:0];
      r_new_lane <= w_rot;
    end else begin
      r_z        <= r_z;
      r_new_lane <= r_new_lane;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign newLane   = r_new_lane;
  assign busy      = r_busy;
  assign lane_err  = r_lane_err;

endmodule

// File: tb/tb_inv_rotate_module.sv
// Self-checking bench for inv_rotate_module (BITS_PER_CYCLE = 1).
// Expected lanes are queued when a job is driven and are compared when the DUT hands its result over.
module tb_inv_rotate_module;

  localparam int BPC = 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] lane;
  logic [4:0]  laneid;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] newLane;
  logic        busy;
  logic        lane_err;

  int n_total;
  int n_bad;
  logic [63:0] exp_q[$];
  logic [5:0]  t_tab[25];

  inv_rotate_module #(.BITS_PER_CYCLE(BPC)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane      (lane),
    .laneid    (laneid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .newLane   (newLane),
    .busy      (busy),
    .lane_err  (lane_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_total++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
    end
  endtask

  function automatic logic [5:0] off_of(input logic [4:0] id);
    return (id <= 5'd24) ? t_tab[id] : 6'd0;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input logic [5:0] t);
    return (t == 6'd0) ? x : ((x << t) | (x >> (7'd64 - {1'b0, t})));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] t);
    return (t == 6'd0) ? x : ((x >> t) | (x << (7'd64 - {1'b0, t})));
  endfunction

  // Run one job: queue the expected lane, accept, check latency and lane_err,
  // optionally hold back out_ready while a new lane is offered, then hand the result over and compare.
  task automatic send(input logic [63:0] l, input logic [4:0] id, input logic [63:0] exp_v, input int hold);
    int cyc;
    int lat_exp;
    logic [63:0] got_exp;
    lat_exp = 64 / BPC + 1;
`ifdef INV_ROT_BYPASS_EN
    if (off_of(id) == 6'd0) lat_exp = 1;
`endif
    exp_q.push_back(exp_v);
    @(negedge clk);
    lane = l; laneid = id; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; lane = ~l; laneid = 5'd3;
    chk("lane_err_pulse", 64'(lane_err), 64'(id > 5'd24));
    chk("busy_after_accept", 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("lane_err_clear", 64'(lane_err), 64'd0);
    end
    chk("latency", 64'(cyc), 64'(lat_exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; lane = 64'h5555_AAAA_5555_AAAA; laneid = 5'd7;
      chk("hold_newLane", newLane, exp_v);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    got_exp = exp_q.pop_front();
    chk("newLane", newLane, got_exp);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] orig;
    logic [63:0] junk;
    n_total = 0; n_bad = 0;
    t_tab = '{6'd21, 6'd8, 6'd41, 6'd45, 6'd15, 6'd56, 6'd14, 6'd18, 6'd2, 6'd61,
              6'd28, 6'd27, 6'd0, 6'd1, 6'd62, 6'd55, 6'd20, 6'd36, 6'd44, 6'd6,
              6'd25, 6'd39, 6'd3, 6'd10, 6'd43};
    t_tab[0] = 6'd0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; lane = 64'd0; laneid = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lane_err", 64'(lane_err), 64'd0);
    chk("rst_newLane", newLane, 64'd0);
    @(negedge clk) rst = 1'b1;

    send(64'h1, 5'd1, 64'h0100_0000_0000_0000, 0);
    send(64'h1, 5'd9, 64'h8, 0);
    send(64'h8000_0000_0000_0000, 5'd14, 64'h2, 0);
    send(64'hDEAD_BEEF_0123_4567, 5'd0, 64'hDEAD_BEEF_0123_4567, 0);

    for (int id = 0; id < 25; id++) begin
      orig = {$urandom, $urandom};
      send(rotl(orig, t_tab[id]), 5'(id), orig, 0);
    end

    orig = {$urandom, $urandom};
    send(orig, 5'd27, orig, 0);
    send(64'h0123_4567_89AB_CDEF, 5'd12, 64'h0123_4567_89AB_CDEF, 0);
    orig = {$urandom, $urandom};
    send(orig, 5'd5, rotr(orig, 6'd56), 10);

    // Abort a job with reset at z = 30.
    junk = 64'hFFFF_0000_FFFF_0000;
    exp_q.push_back(rotr(junk, 6'd45));
    @(negedge clk);
    lane = junk; laneid = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_lane_err", 64'(lane_err), 64'd0);
    chk("abort_newLane", newLane, 64'd0);
    junk = exp_q.pop_front();
    @(negedge clk) rst = 1'b1;
    orig = {$urandom, $urandom};
    send(orig, 5'd2, rotr(orig, 6'd41), 0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
